pio_poll_master: RTL and testbench

Avalon-MM master that periodically reads the data register (address 0) of a PIO input slave, debounces the sampled bits, and reports a stable value plus per-bit rise/fall events to user logic. It sits between the button/switch PIO slaves on the SoC fabric and hardware consumers that need clean key events without going through the Nios II processor. Edge events are also accumulated in a sticky capture register that drives a level interrupt.

---
 rtl/pio_poll_master.sv | 162 ++++++++++++++++
 tb/tb_pio_poll_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_poll_master.sv
// Avalon-MM master that periodically polls a PIO data register, debounces the
// sampled bits and reports a stable value, rise/fall pulses and a sticky edge interrupt.
module pio_poll_master #(
    parameter int DATA_WIDTH    = 4,
    parameter int POLL_INTERVAL = 50000,
    parameter int READ_LATENCY  = 1,
    parameter int STABLE_COUNT  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    output logic [1:0]            avm_address,
    output logic                  avm_read,
    input  logic [31:0]           avm_readdata,
    output logic [DATA_WIDTH-1:0] value,
    output logic                  value_valid,
    output logic [DATA_WIDTH-1:0] rise,
    output logic [DATA_WIDTH-1:0] fall,
    input  logic [DATA_WIDTH-1:0] edge_clear,
    output logic [DATA_WIDTH-1:0] edge_capture,
    output logic                  irq
);

    localparam int TW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int WW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int CW = $clog2(STABLE_COUNT + 1);

    localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_INTERVAL - 1);
    localparam logic [WW-1:0] WAIT_RELOAD  = WW'(READ_LATENCY - 1);
    localparam logic [CW-1:0] CNT_MAX      = CW'(STABLE_COUNT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [WW-1:0]         wait_q, wait_d;
    logic                  read_q, read_d;
    logic [DATA_WIDTH-1:0] cand_q, cand_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] rise_q, rise_d;
    logic [DATA_WIDTH-1:0] fall_q, fall_d;
    logic [DATA_WIDTH-1:0] ec_q, ec_d;
    logic                  irq_q, irq_d;
    logic [DATA_WIDTH-1:0] sample_s;
    logic                  unused_readdata_s;

    assign sample_s          = avm_readdata[DATA_WIDTH-1:0];
    assign unused_readdata_s = ^avm_readdata;

    // Poll sequencing plus debounce/edge evaluation on the sampling edge.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        wait_d  = wait_q;
        read_d  = 1'b0;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        valid_d = valid_q;
        rise_d  = '0;
        fall_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    if (timer_q == '0) begin
                        state_d = ST_READ;
                        read_d  = 1'b1;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end else begin
                    timer_d = TIMER_RELOAD;
                    cnt_d   = '0;
                end
            end
            ST_READ: begin
                state_d = ST_WAIT;
                wait_d  = WAIT_RELOAD;
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_IDLE;
                    timer_d = TIMER_RELOAD;
                    if (sample_s != cand_q) begin
                        cand_d = sample_s;
                        cnt_d  = CW'(1);
                    end else if (cnt_q == CNT_MAX) begin
                        cnt_d = cnt_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    // The very first accepted value only arms value_valid; it is not an edge.
                    if ((cnt_d == CNT_MAX) && (!valid_q || (cand_d != value_q))) begin
                        value_d = cand_d;
                        if (valid_q) begin
                            rise_d = cand_d & ~value_q;
                            fall_d = ~cand_d & value_q;
                        end else begin
                            valid_d = 1'b1;
                        end
                    end else begin
                        value_d = value_q;
                    end
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = TIMER_RELOAD;
            end
        endcase
        // A fresh edge on a bit wins over a clear of the same bit.
        ec_d  = (ec_q & ~edge_clear) | rise_d | fall_d;
        irq_d = |ec_q;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            timer_q <= TIMER_RELOAD;
            wait_q  <= '0;
            read_q  <= 1'b0;
            cand_q  <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            rise_q  <= '0;
            fall_q  <= '0;
            ec_q    <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            wait_q  <= wait_d;
            read_q  <= read_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            valid_q <= valid_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            ec_q    <= ec_d;
            irq_q   <= irq_d;
        end
    end

    assign avm_address  = 2'b00;
    assign avm_read     = read_q;
    assign value        = value_q;
    assign value_valid  = valid_q;
    assign rise         = rise_q;
    assign fall         = fall_q;
    assign edge_capture = ec_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_pio_poll_master.sv
// Bench for pio_poll_master: directed vector table, hand-written corner sequences,
// and randomized traffic compared every cycle against a sample-history reference model.
module tb_pio_poll_master;

    localparam int DW = 4;
    localparam int PI = 4;
    localparam int RL = 1;
    localparam int SC = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic [3:0]  value, rise, fall, edge_clear, edge_capture;
    logic        value_valid, irq;
    logic [3:0]  in_port = 4'h0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    pio_poll_master #(
        .DATA_WIDTH(DW), .POLL_INTERVAL(PI), .READ_LATENCY(RL), .STABLE_COUNT(SC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
        .value(value), .value_valid(value_valid), .rise(rise), .fall(fall),
        .edge_clear(edge_clear), .edge_capture(edge_capture), .irq(irq)
    );

    // PIO slave: registers its port one cycle after a read, junk in the upper bits.
    always @(posedge clk) begin
        if (avm_read) avm_readdata <= {28'($urandom()), in_port};
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts enabled idle cycles, runs a fixed-length transaction,
    // and accepts a value once the last SC samples since enable are all identical.
    typedef struct packed {
        int                  busy;
        int                  idle;
        int                  nsamp;
        logic [SC-1:0][3:0]  hist;
        logic [3:0]          value;
        logic                valid;
        logic [3:0]          rise;
        logic [3:0]          fall;
        logic [3:0]          ec;
        logic                irq;
        logic                rd;
    } m_t;

    m_t m = '0;

    function automatic m_t model_step(input m_t c, input logic en, input logic [3:0] clr,
                                      input logic [3:0] rdata);
        m_t  n;
        logic eq;
        n      = c;
        n.rise = 4'h0;
        n.fall = 4'h0;
        n.irq  = (c.ec != 4'h0);
        if (c.busy > 0) begin
            n.busy = c.busy - 1;
            if (n.busy == 0) begin
                for (int i = SC - 1; i > 0; i--) n.hist[i] = c.hist[i-1];
                n.hist[0] = rdata;
                n.nsamp   = (c.nsamp < SC) ? c.nsamp + 1 : SC;
                eq = 1'b1;
                for (int i = 1; i < SC; i++) if (n.hist[i] != n.hist[0]) eq = 1'b0;
                if (n.nsamp == SC && eq && (!c.valid || n.hist[0] != c.value)) begin
                    n.value = n.hist[0];
                    n.valid = 1'b1;
                    if (c.valid) begin
                        n.rise = n.hist[0] & ~c.value;
                        n.fall = ~n.hist[0] & c.value;
                    end
                end
                n.idle = 0;
            end
        end else if (en) begin
            n.idle = c.idle + 1;
            if (n.idle == PI) begin
                n.busy = RL + 1;
                n.idle = 0;
            end
        end else begin
            n.idle  = 0;
            n.nsamp = 0;
        end
        n.ec = (c.ec & ~clr) | n.rise | n.fall;
        n.rd = (n.busy == RL + 1);
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= '0;
        else          m <= model_step(m, enable, edge_clear, avm_readdata[3:0]);
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            checki("m_read", int'(avm_read), int'(m.rd));
            checki("m_addr", int'(avm_address), 0);
            check4("m_value", value, m.value);
            checki("m_valid", int'(value_valid), int'(m.valid));
            check4("m_rise", rise, m.rise);
            check4("m_fall", fall, m.fall);
            check4("m_ecap", edge_capture, m.ec);
            checki("m_irq", int'(irq), int'(m.irq));
        end
    end

    task automatic wait_read(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (avm_read) begin
                ok = 1'b1;
                break;
            end
        end
        checki("read_seen", int'(ok), 1);
    endtask

    typedef struct packed {
        logic [3:0] din;
        logic [3:0] clr;
        logic [3:0] value;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] ec;
    } vec_t;

    task automatic do_vec(input vec_t v, input logic [3:0] prev_ec);
        bit ok;
        @(negedge clk);
        in_port    = v.din;
        edge_clear = v.clr;
        wait_read(ok);
        @(negedge clk);
        @(negedge clk);
        check4("vec_value", value, v.value);
        check4("vec_rise", rise, v.rise);
        check4("vec_fall", fall, v.fall);
        check4("vec_ecap", edge_capture, v.ec);
        checki("vec_valid", int'(value_valid), 1);
        checki("vec_irq_old", int'(irq), int'(prev_ec != 4'h0));
        edge_clear = 4'h0;
        @(negedge clk);
        check4("vec_rise_pulse", rise, 4'h0);
        check4("vec_fall_pulse", fall, 4'h0);
        checki("vec_irq_new", int'(irq), int'(v.ec != 4'h0));
    endtask

    vec_t tbl [13];

    initial begin
        bit         ok;
        int         reads;
        logic [3:0] prev_ec;

        //            din   clr   value rise  fall  ec
        tbl[0]  = '{4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[1]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[2]  = '{4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[3]  = '{4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[4]  = '{4'h5, 4'h0, 4'h5, 4'h5, 4'h0, 4'h5};
        tbl[5]  = '{4'hA, 4'h0, 4'h5, 4'h0, 4'h0, 4'h5};
        tbl[6]  = '{4'hA, 4'h0, 4'h5, 4'h0, 4'h0, 4'h5};
        tbl[7]  = '{4'hA, 4'h0, 4'hA, 4'hA, 4'h5, 4'hF};
        tbl[8]  = '{4'hB, 4'h0, 4'hA, 4'h0, 4'h0, 4'h0};
        tbl[9]  = '{4'hB, 4'h0, 4'hA, 4'h0, 4'h0, 4'h0};
        tbl[10] = '{4'hB, 4'h1, 4'hB, 4'h1, 4'h0, 4'h1};
        tbl[11] = '{4'h4, 4'h0, 4'hB, 4'h0, 4'h0, 4'h1};
        tbl[12] = '{4'h4, 4'h0, 4'hB, 4'h0, 4'h0, 4'h1};

        edge_clear = 4'h0;
        enable     = 1'b1;
        in_port    = 4'h0;
        repeat (3) @(negedge clk);
        check4("reset_value", value, 4'h0);
        checki("reset_irq", int'(irq), 0);
        #2 reset_n = 1'b1;

        // Read schedule and first acceptance.
        wait_read(ok); checki("read_cycle_a", cyc, 4);
        wait_read(ok); checki("read_cycle_b", cyc, 10);
        wait_read(ok); checki("read_cycle_c", cyc, 16);
        @(negedge clk);
        checki("valid_before", int'(value_valid), 0);
        @(negedge clk);
        checki("valid_after", int'(value_valid), 1);
        check4("first_value", value, 4'h0);
        check4("first_rise", rise, 4'h0);
        check4("first_fall", fall, 4'h0);

        prev_ec = 4'h0;
        for (int i = 0; i < 8; i++) begin
            do_vec(tbl[i], prev_ec);
            prev_ec = tbl[i].ec;
        end

        // Partial and full clears of the capture register.
        @(negedge clk); edge_clear = 4'h3;
        @(negedge clk);
        check4("clr3_ecap", edge_capture, 4'hC);
        checki("clr3_irq", int'(irq), 1);
        edge_clear = 4'hC;
        @(negedge clk);
        check4("clrC_ecap", edge_capture, 4'h0);
        checki("clrC_irq_lag", int'(irq), 1);
        edge_clear = 4'h0;
        @(negedge clk);
        checki("clrC_irq", int'(irq), 0);

        prev_ec = 4'h0;
        for (int i = 8; i < 13; i++) begin
            do_vec(tbl[i], prev_ec);
            prev_ec = tbl[i].ec;
        end

        // Drop enable during WAIT: the sample still lands, then polling stops.
        wait_read(ok);
        @(negedge clk); enable = 1'b0;
        @(negedge clk);
        check4("drop_value", value, 4'h4);
        check4("drop_rise", rise, 4'h4);
        check4("drop_fall", fall, 4'hB);
        check4("drop_ecap", edge_capture, 4'hF);
        reads = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (avm_read) reads++;
        end
        checki("no_read_disabled", reads, 0);

        // Asynchronous reset in the middle of a transaction.
        @(negedge clk); enable = 1'b1;
        wait_read(ok);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check4("rst_value", value, 4'h0);
        checki("rst_valid", int'(value_valid), 0);
        check4("rst_ecap", edge_capture, 4'h0);
        checki("rst_irq", int'(irq), 0);
        checki("rst_read", int'(avm_read), 0);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        wait_read(ok);
        checki("read_after_reset", cyc, 4);

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) in_port = 4'($urandom());
            if (enable) begin
                if ($urandom_range(0, 79) == 0) enable = 1'b0;
            end else begin
                if ($urandom_range(0, 9) == 0) enable = 1'b1;
            end
            edge_clear = ($urandom_range(0, 7) == 0) ? 4'($urandom()) : 4'h0;
            if ($urandom_range(0, 999) == 0) begin
                #2 reset_n = 1'b0;
                @(negedge clk);
                #2 reset_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
